// File: rtl/ksa_pkg.sv
// ksa_pkg: shared constants and prefix-cell helpers for the pipelined Kogge-Stone adder
package ksa_pkg;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic logic [1:0] combine(input logic gi, input logic pi, input logic gj, input logic pj);
    return {gi | (pi & gj), pi & pj};
  endfunction
endpackage

// File: rtl/ksa_prefix_level.sv
// ksa_prefix_level: one registered Kogge-Stone prefix level of span SPAN
module ksa_prefix_level import ksa_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int SPAN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_p,
  input  logic [WIDTH-1:0] in_g,
  input  logic [WIDTH-1:0] in_pp,
  input  logic             in_c0,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_p,
  output logic [WIDTH-1:0] out_g,
  output logic [WIDTH-1:0] out_pp,
  output logic             out_c0
);
  logic [WIDTH-1:0] g_n, pp_n;
  always_comb begin
    g_n = in_g;
    pp_n = in_pp;
    for (int i = SPAN; i < WIDTH; i++) {g_n[i], pp_n[i]} = combine(in_g[i], in_pp[i], in_g[i-SPAN], in_pp[i-SPAN]);
  end
  always_ff @(posedge clk) begin
    if (rst) out_valid <= 1'b0;
    else if (adv) begin
      out_valid <= in_valid;
      out_p <= in_p;
      out_g <= g_n;
      out_pp <= pp_n;
      out_c0 <= in_c0;
    end
  end
endmodule

// File: rtl/ksa_pipe.sv
// ksa_pipe: pipelined Kogge-Stone adder/subtractor, one register per prefix level, valid/ready stall
module ksa_pipe import ksa_pkg::*; #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int LEVELS = clog2(WIDTH);
  logic adv, c0, v0, c0_q;
  logic [WIDTH-1:0] bx, p0, g0, cy, sum_n;
  logic v_s [LEVELS+1];
  logic c_s [LEVELS+1];
  logic [WIDTH-1:0] p_s [LEVELS+1];
  logic [WIDTH-1:0] g_s [LEVELS+1];
  logic [WIDTH-1:0] pp_s [LEVELS+1];
  assign adv = out_ready | ~out_valid;
  assign in_ready = adv;
  assign bx = sub ? ~b : b;
  assign c0 = sub | cin;
  // carry-in is folded into bit 0 as the generate of a virtual bit -1
  always_ff @(posedge clk) begin
    if (rst) v0 <= 1'b0;
    else if (adv) begin
      v0 <= in_valid;
      p0 <= a ^ bx;
      g0 <= (a & bx) | {{(WIDTH-1){1'b0}}, (a[0] ^ bx[0]) & c0};
      c0_q <= c0;
    end
  end
  assign v_s[0] = v0;
  assign p_s[0] = p0;
  assign g_s[0] = g0;
  assign pp_s[0] = p0;
  assign c_s[0] = c0_q;
  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    ksa_prefix_level #(.WIDTH(WIDTH), .SPAN(1 << (k-1))) u_lvl (
      .clk(clk),
      .rst(rst),
      .adv(adv),
      .in_valid(v_s[k-1]),
      .in_p(p_s[k-1]),
      .in_g(g_s[k-1]),
      .in_pp(pp_s[k-1]),
      .in_c0(c_s[k-1]),
      .out_valid(v_s[k]),
      .out_p(p_s[k]),
      .out_g(g_s[k]),
      .out_pp(pp_s[k]),
      .out_c0(c_s[k])
    );
  end
  assign cy = g_s[LEVELS];
  assign sum_n = p_s[LEVELS] ^ {cy[WIDTH-2:0], c_s[LEVELS]};
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum <= '0;
      cout <= 1'b0;
      ovf <= 1'b0;
    end else if (adv) begin
      out_valid <= v_s[LEVELS];
      if (v_s[LEVELS]) begin
        sum <= sum_n;
        cout <= cy[WIDTH-1];
        ovf <= cy[WIDTH-2] ^ cy[WIDTH-1];
      end
    end
  end
endmodule
